// File: rtl/angstrom_pkg.sv
// angstrom_pkg: constants and types shared by the pc and the call stack.
//   ADDR_W       instruction address width, common to pc and call_stack
//   STACK_DEPTH  default number of return-address entries
//   req_e        classification of one cycle's CALL/RET request
//   decode_req   maps the raw request lines plus stack state onto req_e
package angstrom_pkg;

    localparam int ADDR_W      = 12;
    localparam int STACK_DEPTH = 8;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_CALL,
        REQ_RET,
        REQ_OVERFLOW,
        REQ_UNDERFLOW,
        REQ_CONFLICT
    } req_e;

    // Full/empty are the values from the depth registered before this edge,
    // so a request every cycle is judged against the settled stack state.
    function automatic req_e decode_req(
        input logic call,
        input logic ret,
        input logic full,
        input logic empty
    );
        req_e r;
        r = REQ_NONE;
        if (call && ret) begin
            r = REQ_CONFLICT;
        end else if (call) begin
            r = full ? REQ_OVERFLOW : REQ_CALL;
        end else if (ret) begin
            r = empty ? REQ_UNDERFLOW : REQ_RET;
        end
        return r;
    endfunction

endpackage

// File: rtl/call_stack_lifo_mem.sv
// lifo_mem: DEPTH x WIDTH register array backing the return-address stack.
//   clk_i    clock, writes on the rising edge
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index
//   rdata_o  read data, combinational from raddr_i
// Contents are not reset; a slot is only read after it has been written.
module lifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/call_stack.sv
// call_stack: return-address stack feeding the pc's jump inputs.
//   clk_i, rst_i         clock; asynchronous active-high reset
//   call_i, ret_i        CALL / RET request for this cycle
//   pc_i                 current instruction address
//   call_addr_i          CALL target
//   jmp_en_o, jmp_addr_o registered one-cycle jump strobe and target
//   depth_o, full_o, empty_o   stack occupancy (combinational from depth)
//   overflow_o, underflow_o, conflict_o   sticky error flags
// CALL pushes pc_i+1 and jumps to call_addr_i; RET pops and jumps to the
// popped address. Rejected requests produce no strobe and set a flag.
module call_stack #(
    parameter int ADDR_W = angstrom_pkg::ADDR_W,
    parameter int DEPTH  = angstrom_pkg::STACK_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       call_i,
    input  logic                       ret_i,
    input  logic [ADDR_W-1:0]          pc_i,
    input  logic [ADDR_W-1:0]          call_addr_i,
    output logic                       jmp_en_o,
    output logic [ADDR_W-1:0]          jmp_addr_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    output logic                       conflict_o
);

    import angstrom_pkg::*;

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DW-1:0]     depth_q, depth_d;
    logic              jmp_en_q, jmp_en_d;
    logic [ADDR_W-1:0] jmp_addr_q, jmp_addr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              conflict_q, conflict_d;

    req_e              req;
    logic              mem_we;
    logic [IW-1:0]     waddr;
    logic [IW-1:0]     raddr;
    logic [ADDR_W-1:0] push_data;
    logic [ADDR_W-1:0] top_data;

    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    assign req = decode_req(call_i, ret_i, full_o, empty_o);

    // A push only happens when not full, so depth fits in the index width;
    // the pop index wraps when empty but is then never used.
    assign waddr     = depth_q[IW-1:0];
    assign raddr     = depth_q[IW-1:0] - IW'(1);
    assign push_data = pc_i + ADDR_W'(1);
    assign mem_we    = (req == REQ_CALL);

    lifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (waddr),
        .wdata_i (push_data),
        .raddr_i (raddr),
        .rdata_o (top_data)
    );

    always_comb begin
        depth_d     = depth_q;
        jmp_en_d    = 1'b0;
        jmp_addr_d  = jmp_addr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        conflict_d  = conflict_q;
        case (req)
            REQ_CALL: begin
                depth_d    = depth_q + DW'(1);
                jmp_en_d   = 1'b1;
                jmp_addr_d = call_addr_i;
            end
            REQ_RET: begin
                depth_d    = depth_q - DW'(1);
                jmp_en_d   = 1'b1;
                jmp_addr_d = top_data;
            end
            REQ_OVERFLOW:  overflow_d  = 1'b1;
            REQ_UNDERFLOW: underflow_d = 1'b1;
            REQ_CONFLICT:  conflict_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            depth_q     <= '0;
            jmp_en_q    <= 1'b0;
            jmp_addr_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            jmp_en_q    <= jmp_en_d;
            jmp_addr_q  <= jmp_addr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            conflict_q  <= conflict_d;
        end
    end

    assign jmp_en_o    = jmp_en_q;
    assign jmp_addr_o  = jmp_addr_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign conflict_o  = conflict_q;

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: directed-vector bench for call_stack (ADDR_W=12, DEPTH=8).
module tb_call_stack;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        call_i;
    logic        ret_i;
    logic [11:0] pc_i;
    logic [11:0] call_addr_i;
    logic        jmp_en_o;
    logic [11:0] jmp_addr_o;
    logic [3:0]  depth_o;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        conflict_o;

    int n_checks = 0;
    int n_pass   = 0;

    call_stack #(
        .ADDR_W (12),
        .DEPTH  (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .call_i      (call_i),
        .ret_i       (ret_i),
        .pc_i        (pc_i),
        .call_addr_i (call_addr_i),
        .jmp_en_o    (jmp_en_o),
        .jmp_addr_o  (jmp_addr_o),
        .depth_o     (depth_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .conflict_o  (conflict_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one request, let it be taken on the next rising edge, then
    // sample 1 time unit later and return the inputs to idle.
    task automatic step(input logic call, input logic ret,
                        input logic [11:0] pc, input logic [11:0] tgt);
        call_i      = call;
        ret_i       = ret;
        pc_i        = pc;
        call_addr_i = tgt;
        @(posedge clk_i);
        #1;
        call_i = 1'b0;
        ret_i  = 1'b0;
        $display("step call=%0b ret=%0b pc=%03h tgt=%03h -> jmp_en=%0b jmp_addr=%03h depth=%0d",
                 call, ret, pc, tgt, jmp_en_o, jmp_addr_o, depth_o);
    endtask

    initial begin
        rst_i = 1'b1; call_i = 1'b0; ret_i = 1'b0; pc_i = '0; call_addr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_depth", depth_o, 0);
        check("rst_jmp_en", jmp_en_o, 0);
        check("rst_jmp_addr", jmp_addr_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_flags", {overflow_o, underflow_o, conflict_o}, 0);
        rst_i = 1'b0;

        // Asynchronous reset mid-cycle while a CALL strobe is showing and
        // another CALL is pending for the next edge.
        step(1'b1, 1'b0, 12'h050, 12'h0AA);
        check("pre_rst_jmp_en", jmp_en_o, 1);
        call_i = 1'b1; pc_i = 12'h060; call_addr_i = 12'h0BB;
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_depth", depth_o, 0);
        check("async_rst_jmp_en", jmp_en_o, 0);
        check("async_rst_jmp_addr", jmp_addr_o, 0);
        check("async_rst_empty", empty_o, 1);
        call_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("after_rst_jmp_en", jmp_en_o, 0);

        // Single CALL / RET pair.
        step(1'b1, 1'b0, 12'h010, 12'h0F0);
        check("call_jmp_en", jmp_en_o, 1);
        check("call_jmp_addr", jmp_addr_o, 12'h0F0);
        check("call_depth", depth_o, 1);
        step(1'b0, 1'b1, 12'h0F0, 12'h000);
        check("ret_jmp_en", jmp_en_o, 1);
        check("ret_jmp_addr", jmp_addr_o, 12'h011);
        check("ret_depth", depth_o, 0);
        step(1'b0, 1'b0, 12'h000, 12'h000);
        check("idle_jmp_en", jmp_en_o, 0);
        check("idle_jmp_addr_hold", jmp_addr_o, 12'h011);

        // Nested calls, back to back.
        step(1'b1, 1'b0, 12'h100, 12'h400);
        check("nest1_addr", jmp_addr_o, 12'h400);
        step(1'b1, 1'b0, 12'h200, 12'h500);
        check("nest2_en", jmp_en_o, 1);
        step(1'b1, 1'b0, 12'h300, 12'h600);
        check("nest3_depth", depth_o, 3);
        step(1'b0, 1'b1, 12'h600, 12'h000);
        check("unnest1_en", jmp_en_o, 1);
        check("unnest1_addr", jmp_addr_o, 12'h301);
        step(1'b0, 1'b1, 12'h301, 12'h000);
        check("unnest2_en", jmp_en_o, 1);
        check("unnest2_addr", jmp_addr_o, 12'h201);
        step(1'b0, 1'b1, 12'h201, 12'h000);
        check("unnest3_en", jmp_en_o, 1);
        check("unnest3_addr", jmp_addr_o, 12'h101);
        step(1'b0, 1'b0, 12'h000, 12'h000);
        check("unnest_strobe_end", jmp_en_o, 0);
        check("unnest_empty", empty_o, 1);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 12'h700 + 12'(i), 12'h800 + 12'(i));
        end
        check("fill_full", full_o, 1);
        check("fill_depth", depth_o, 8);
        check("fill_last_addr", jmp_addr_o, 12'h807);
        check("fill_no_ovf", overflow_o, 0);
        step(1'b1, 1'b0, 12'h7FF, 12'hABC);
        check("ovf_no_strobe", jmp_en_o, 0);
        check("ovf_flag", overflow_o, 1);
        check("ovf_depth", depth_o, 8);
        check("ovf_addr_hold", jmp_addr_o, 12'h807);
        step(1'b0, 1'b1, 12'h000, 12'h000);
        check("ovf_ret_addr", jmp_addr_o, 12'h708);
        check("ovf_ret_depth", depth_o, 7);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 12'h000, 12'h000);
        end
        check("drain_addr", jmp_addr_o, 12'h701);
        check("drain_empty", empty_o, 1);
        check("drain_no_unf", underflow_o, 0);

        // Underflow, then simultaneous CALL+RET.
        step(1'b0, 1'b1, 12'h000, 12'h000);
        check("unf_no_strobe", jmp_en_o, 0);
        check("unf_flag", underflow_o, 1);
        check("unf_depth", depth_o, 0);
        check("no_conflict_yet", conflict_o, 0);
        step(1'b1, 1'b1, 12'h020, 12'h0C0);
        check("conf_no_strobe", jmp_en_o, 0);
        check("conf_flag", conflict_o, 1);
        check("conf_depth", depth_o, 0);
        check("conf_addr_hold", jmp_addr_o, 12'h701);

        // Push value wraps at the top of the address space.
        step(1'b1, 1'b0, 12'hFFF, 12'h123);
        check("wrap_call_addr", jmp_addr_o, 12'h123);
        step(1'b0, 1'b0, 12'h000, 12'h000);
        step(1'b0, 1'b1, 12'h123, 12'h000);
        check("wrap_ret_en", jmp_en_o, 1);
        check("wrap_ret_addr", jmp_addr_o, 12'h000);
        check("sticky_hold", {overflow_o, underflow_o, conflict_o}, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Return-address stack that drives the program counter's jump inputs (jmp_en/jmp_addr) for CALL and RET instructions.
- On CALL it pushes the address after the call (pc_i + 1) and redirects the PC to the call target.
- On RET it pops the saved address and redirects the PC there.
- Sits between instruction decode and the pc block; its jmp_en_o/jmp_addr_o feed the pc's jmp_en_i/jmp_addr_i.

Parameters:
- ADDR_W, 12, width of the instruction address (matches the pc block).
- DEPTH, 8, number of stack entries; power of two, at least 2.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- call_i  input  1  CALL request this cycle.
- ret_i  input  1  RET request this cycle.
- pc_i  input  ADDR_W  current instruction address (the pc's addr_o).
- call_addr_i  input  ADDR_W  CALL target address.
- jmp_en_o  output  1  one-cycle jump strobe to the pc.
- jmp_addr_o  output  ADDR_W  jump target to the pc.
- depth_o  output  $clog2(DEPTH+1)  number of occupied entries.
- full_o  output  1  depth_o == DEPTH.
- empty_o  output  1  depth_o == 0.
- overflow_o  output  1  sticky: a CALL was made while full.
- underflow_o  output  1  sticky: a RET was made while empty.
- conflict_o  output  1  sticky: call_i and ret_i were asserted in the same cycle.

Behaviour:
- Reset:
  - Asynchronous: takes effect immediately on rst_i high, regardless of clk_i.
  - Values while reset is high: depth 0, jmp_en_o 0, jmp_addr_o 0, all sticky flags 0, empty_o 1, full_o 0.
  - Stack entries are not reset; their contents are only ever observable through a pop.
  - A reset during back-to-back CALL/RET traffic discards everything, including any jump strobe due in the next cycle.
- Latency: jmp_en_o and jmp_addr_o are registered and respond exactly 1 cycle after the request edge.
- Strobe: jmp_en_o is high for exactly one cycle per accepted request. jmp_addr_o holds its last value when there is no strobe.
- CALL (call_i=1, ret_i=0, not full):
  - Store (pc_i + 1) mod 2^ADDR_W at index depth; depth increments by 1.
  - Next cycle: jmp_en_o=1, jmp_addr_o=call_addr_i.
- RET (ret_i=1, call_i=0, not empty):
  - Depth decrements by 1.
  - Next cycle: jmp_en_o=1, jmp_addr_o=entry[depth-1].
- CALL while full: no push, no jump strobe; overflow_o is set; depth is unchanged.
- RET while empty: no pop, no jump strobe; underflow_o is set.
- call_i and ret_i in the same cycle: no stack change, no strobe; conflict_o is set.
- Back-to-back requests:
  - A new request is accepted every cycle; there is no stall.
  - Full/empty decisions use the depth registered before the current edge.
  - CALL then RET on consecutive cycles returns the address pushed by that CALL.
- Wrap-around: the push value at pc_i = 2^ADDR_W - 1 is 0.
- Sticky flags clear only on reset.
- full_o, empty_o and depth_o are driven combinationally from the registered depth.

Decomposition:
- Shared package angstrom_pkg holds ADDR_W (12) and the default stack depth constant, so pc and call_stack stay width-consistent.
- One sub-module, lifo_mem: a DEPTH x ADDR_W register array with write port (we, waddr, wdata) and combinational read port (raddr, rdata), no reset.
- call_stack keeps the depth pointer, request decode, error flags and output registers.

Test Plan:
- Reset, then pulse rst_i high mid-cycle during a CALL -> outputs go to reset values immediately, without waiting for a clock edge; depth_o=0, jmp_en_o=0, empty_o=1.
- CALL with pc_i=0x010, call_addr_i=0x0F0 -> next cycle jmp_en_o=1, jmp_addr_o=0x0F0, depth_o=1; then RET -> next cycle jmp_en_o=1, jmp_addr_o=0x011, depth_o=0.
- Nested CALLs at pc_i=0x100, 0x200, 0x300, then three RETs -> jmp_addr_o sequence 0x301, 0x201, 0x101; one-cycle strobe each; empty_o=1 at end.
- Eight CALLs, then a ninth (DEPTH=8) -> full_o=1, the ninth gives no strobe, overflow_o=1, depth_o stays 8; next RET returns the eighth pushed address.
- RET while empty -> no strobe, underflow_o=1, depth_o=0. Then call_i=ret_i=1 -> no strobe, conflict_o=1, depth unchanged.
- CALL with pc_i=0xFFF -> a later RET yields jmp_addr_o=0x000.
